wb_port_arbiter: RTL

- Shares the single register-file write-back port (reg_write / data_write) among N_REQ functional-unit result sources: ALU, load unit, mul/div, and so on.
- Round-robin grants, one winner per cycle. Registered output: one write event per cycle at most.
- Inserts bubbles so the register file's change-triggered write logic never misses a write. Sits between the EX/MEM result sources and the ID-stage register file.

---
 rtl/wb_port_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write-back port among N_REQ result sources.
// Inserts a one-cycle bubble when a grant would repeat the current (rd, data) pair.
module wb_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*REG_W-1:0]  req_rd,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wb_hold,
  output logic [REG_W-1:0]        reg_write,
  output logic [DATA_W-1:0]       data_write,
  output logic                    wb_busy,
  output logic [CNT_W-1:0]        wb_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [REG_W-1:0]  reg_write_q, reg_write_d;
  logic [DATA_W-1:0] data_write_q, data_write_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;

  logic [REG_W-1:0]  src_rd   [N_REQ];
  logic [DATA_W-1:0] src_data [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_src
      assign src_rd[gi]   = req_rd[gi*REG_W +: REG_W];
      assign src_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic              cand_found;
  logic [PTR_W-1:0]  cand_idx;
  logic [REG_W-1:0]  cand_rd;
  logic [DATA_W-1:0] cand_data;
  logic              bubble;
  logic              grant;

  // Walk offsets from the far end so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_rd    = '0;
    cand_data  = '0;
    idx        = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req_valid[idx]) begin
        cand_found = 1'b1;
        cand_idx   = PTR_W'(idx);
        cand_rd    = src_rd[idx];
        cand_data  = src_data[idx];
      end
    end
  end

  // The register file only sees changes, so an identical repeat must wait one cycle.
  assign bubble = (reg_write_q != '0) && (cand_rd == reg_write_q) && (cand_data == data_write_q);
  assign grant  = rst && !wb_hold && cand_found && !bubble;

  assign req_ready = grant ? (N_REQ'(1) << cand_idx) : '0;
  assign wb_busy   = (|req_valid) && !grant;

  always_comb begin
    ptr_d        = ptr_q;
    reg_write_d  = '0;
    data_write_d = data_write_q;
    wb_count_d   = wb_count_q;
    if (grant) begin
      ptr_d = (cand_idx == PTR_W'(N_REQ - 1)) ? '0 : cand_idx + PTR_W'(1);
      if (cand_rd != '0) begin
        reg_write_d  = cand_rd;
        data_write_d = cand_data;
        if (wb_count_q != '1) begin
          wb_count_d = wb_count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= '0;
      reg_write_q  <= '0;
      data_write_q <= '0;
      wb_count_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= reg_write_d;
      data_write_q <= data_write_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign data_write = data_write_q;
  assign wb_count   = wb_count_q;

endmodule
